// File: rtl/pwm_dead_time.sv
// Frame-based PWM with complementary dead-time-separated half-bridge drive and latched fault.
// Outputs lag the raw comparator by one clock; all state updates on the falling edge of Clk.
module pwm_dead_time #(
  parameter int N     = 8,
  parameter int DeadN = 4
) (
  input  logic             nReset,
  input  logic             Clk,
  input  logic             Enable,
  input  logic             Fault,
  input  logic [N-1:0]     Duty,
  input  logic [DeadN-1:0] DeadTime,
  output logic             Sync,
  output logic             OutH,
  output logic             OutL,
  output logic             Busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [N-1:0]     count;
  logic [N-1:0]     count_nx;
  logic [N-1:0]     duty_reg;
  logic [N-1:0]     duty_nx;
  logic [DeadN-1:0] dc;
  logic [DeadN-1:0] dc_nx;
  logic             pd;
  logic             pd_nx;
  logic             out_h_nx;
  logic             out_l_nx;
  logic             p;

  always_ff @(negedge Clk or negedge nReset) begin
    if (!nReset) begin
      state    <= IDLE;
      count    <= '0;
      duty_reg <= '0;
      dc       <= '0;
      pd       <= 1'b0;
      OutH     <= 1'b0;
      OutL     <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      count    <= count_nx;
      duty_reg <= duty_nx;
      dc       <= dc_nx;
      pd       <= pd_nx;
      OutH     <= out_h_nx;
      OutL     <= out_l_nx;
      Busy     <= (state_nx == RUN);
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    duty_nx  = duty_reg;
    dc_nx    = dc;
    pd_nx    = pd;
    out_h_nx = 1'b0;
    out_l_nx = 1'b0;
    p        = (count < duty_reg);

    if (Fault) begin
      state_nx = FAULT;
    end else begin
      case (state)
        IDLE:    if (Enable)  state_nx = RUN;
        RUN:     if (!Enable) state_nx = IDLE;
        FAULT:   if (!Enable) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end

    if (state_nx != RUN) begin
      count_nx = '0;
    end else if (state != RUN) begin
      // Start of run: treat entry as a transition so the first drive gets a full gap.
      count_nx = '0;
      duty_nx  = Duty;
      pd_nx    = 1'b0;
      dc_nx    = (DeadTime == '0) ? '0 : DeadTime - 1'b1;
    end else begin
      count_nx = count + 1'b1;
      if (count == '1) duty_nx = Duty;
      pd_nx = p;
      if (p != pd) begin
        if (DeadTime == '0) begin
          out_h_nx = p;
          out_l_nx = ~p;
        end else begin
          dc_nx = DeadTime - 1'b1;
        end
      end else if (dc != '0) begin
        dc_nx = dc - 1'b1;
      end else begin
        out_h_nx = p;
        out_l_nx = ~p;
      end
    end
  end

  assign Sync = (state == RUN) && (count == '1);

endmodule
